// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_cell.sv
// One-bit full-adder cell; the only arithmetic in the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry held in a flop.
// state   | meaning
// S_IDLE  | waiting for start; last result held on sum_out/cout
// S_SHIFT | one bit pair per clock through the cell
// S_DONE  | publish sum/carry to the output registers
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0]   sum_out_q, sum_out_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cell_sum;
  logic               cell_cout;

  full_adder_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .c    (carry_q),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_sr_d  = sum_sr_q;
    sum_out_d = sum_out_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = a_in;
          b_d       = b_in;
          carry_d   = cin;
          sum_sr_d  = '0;
          cnt_d     = '0;
          sum_out_d = '0;
          cout_d    = 1'b0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sum_sr_d = {cell_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        // Outputs are registered, so the done pulse lands one cycle after this state.
        sum_out_d = sum_sr_q;
        cout_d    = carry_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_sr_q  <= '0;
      sum_out_q <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_sr_q  <= sum_sr_d;
      sum_out_q <= sum_out_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = done_q;
  assign sum_out = sum_out_q;
  assign cout    = cout_q;

endmodule
